alu_acc: RTL and testbench
==========================

ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning datapath and accumulator width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to execute op on operand this cycle.
REQ-005 SHALL have port op  input  3  operation code, alu_pkg::op_e.
REQ-006 SHALL have port operand  input  WIDTH  second operand, driven from the register file read port.
REQ-007 SHALL have port acc  output  WIDTH  accumulator value, fed back to the register file write data.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress; start is ignored.
REQ-009 SHALL have port done  output  1  one-cycle pulse in the cycle acc holds a new result; doubles as the register file write-enable.
REQ-010 SHALL have ports zf and cf  output  1 each  zero and carry flags.

Function
REQ-011 SHALL have FSM states IDLE and MUL; busy = (state == MUL).
REQ-012 SHALL accept start only in IDLE; start in MUL SHALL be ignored, with no effect on state, acc or flags.
REQ-013 SHALL execute single-cycle ops when accepted: acc updates at the next edge, done high for the following cycle only.
REQ-014 SHALL encode ops: 000 LD acc=operand; 001 ADD; 010 SUB acc-operand; 011 AND; 100 OR; 101 XOR; 110 SHL acc<<1; 111 MUL.
REQ-015 SHALL compute ADD/SUB modulo 2^WIDTH; cf = carry-out for ADD, borrow (operand > acc, unsigned) for SUB.
REQ-016 SHALL for SHL set cf = old acc MSB and shift in 0; LD and logic ops SHALL clear cf.
REQ-017 SHALL update zf = (new acc == 0) on every completed op; flags SHALL hold between ops.
REQ-018 SHALL for MUL latch acc and operand, enter MUL, and run shift-add for exactly WIDTH cycles; busy high for WIDTH cycles, done pulses in the cycle after return to IDLE.
REQ-019 SHALL for MUL write the low WIDTH bits of the unsigned product to acc, set cf = (high half != 0), and leave acc unchanged until completion.
REQ-020 SHALL accept back-to-back starts in consecutive IDLE cycles; each produces its own done pulse.
REQ-021 SHALL allow start in the same cycle busy falls, i.e. the cycle done is high.

Reset
REQ-022 SHALL, when rst is low at a clock edge, set acc=0, zf=1, cf=0, done=0, state=IDLE, aborting any MUL without a done pulse.
REQ-023 SHALL give reset priority over start in the same cycle.

Configuration
REQ-024 SHALL, with macro ALU_ACC_MUL_EN defined, implement MUL per REQ-018/019.
REQ-025 SHALL, without ALU_ACC_MUL_EN, treat op 111 as a single-cycle NOP: acc and flags unchanged, done pulses, busy never asserts, no multiplier logic synthesized.

Structure
REQ-026 SHALL place the op_e enum (3-bit) and the state enum in package alu_pkg.
REQ-027 SHALL implement the shift-add iteration in sub-module mul_seq (start, operands in; product, valid out), instantiated only under ALU_ACC_MUL_EN.

Verification
REQ-028 SHALL cover: reset, LD 0x05 -> acc=0x05, zf=0, cf=0, done one cycle.
REQ-029 SHALL cover: acc=0xF0, ADD 0x20 -> acc=0x10, cf=1, zf=0; then SUB 0x10 -> acc=0x00, zf=1, cf=0.
REQ-030 SHALL cover: acc=0x03, SUB 0x05 -> acc=0xFE, cf=1; then SHL -> acc=0xFC, cf=1.
REQ-031 SHALL cover: acc=0x12, MUL 0x10 -> busy for 8 cycles, then acc=0x20, cf=1, done once; start pulsed mid-MUL has no effect.
REQ-032 SHALL cover: rst low at the 4th MUL cycle -> acc=0, zf=1, busy=0, no done.
REQ-033 SHALL cover: built without ALU_ACC_MUL_EN, acc=0x07, op 111 -> acc=0x07, flags held, done after one cycle, busy stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared types for the accumulator ALU.
//   op_e    : 3-bit operation code driven on alu_acc.op
//   state_e : control state of alu_acc (IDLE / MUL)
// Optional feature macro (used by alu_acc): ALU_ACC_MUL_EN enables the
// sequential multiplier; without it op MUL is a single-cycle NOP.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_LD  = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq -- unsigned shift-add multiplier, one partial product per cycle.
// Only instantiated when ALU_ACC_MUL_EN is defined.
// Ports:
//   clk      : clock
//   rst      : synchronous active-low reset (aborts a running multiply)
//   start    : latch a and b and begin; must only be pulsed while idle
//   a, b     : WIDTH-bit multiplicand / multiplier
//   product  : 2*WIDTH-bit result, meaningful while valid is high
//   valid    : high during the last (WIDTH-th) iteration cycle
// The product is presented combinationally on the final iteration so the
// parent can capture it on the same edge that finishes the multiply; this
// keeps the parent's busy window at exactly WIDTH cycles.
// ---------------------------------------------------------------------------
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [CW-1:0]      cnt_reg;
    logic               run_reg;
    logic [2*WIDTH-1:0] prod_next;

    // Add the shifted multiplicand when the current multiplier LSB is set.
    always_comb begin
        prod_next = prod_reg;
        if (mplier_reg[0]) begin
            prod_next = prod_reg + mcand_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b1;
        end else if (run_reg) begin
            prod_reg   <= prod_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(WIDTH - 1)) begin
                run_reg <= 1'b0;
            end
        end
    end

    assign product = prod_next;
    assign valid   = run_reg && (cnt_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_acc.sv
// ---------------------------------------------------------------------------
// alu_acc -- accumulator ALU: acc <= acc OP operand, with zero/carry flags.
// Ports:
//   clk     : clock, all state on posedge
//   rst     : synchronous active-low reset (priority over start)
//   start   : execute op on operand this cycle (ignored while busy)
//   op      : alu_pkg::op_e operation code
//   operand : second operand
//   acc     : accumulator
//   busy    : high while a multiply is in progress
//   done    : one-cycle pulse when acc holds a new result (write enable)
//   zf, cf  : zero and carry/borrow flags, held between operations
// Build option: define ALU_ACC_MUL_EN to include the WIDTH-cycle shift-add
// multiplier (mul_seq). Otherwise op MUL is a single-cycle NOP.
// ---------------------------------------------------------------------------
module alu_acc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             zf,
    output logic             cf
);

    state_e           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             done_reg;
    logic             zf_reg;
    logic             cf_reg;

    logic [WIDTH-1:0] res_next;
    logic             cf_next;
    logic             zf_next;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;

    // The extra top bit of the widened difference is the unsigned borrow.
    assign add_w = {1'b0, acc_reg} + {1'b0, operand};
    assign sub_w = {1'b0, acc_reg} - {1'b0, operand};

    always_comb begin
        res_next = acc_reg;
        cf_next  = 1'b0;
        case (op)
            OP_LD:  res_next = operand;
            OP_ADD: begin res_next = add_w[WIDTH-1:0]; cf_next = add_w[WIDTH]; end
            OP_SUB: begin res_next = sub_w[WIDTH-1:0]; cf_next = sub_w[WIDTH]; end
            OP_AND: res_next = acc_reg & operand;
            OP_OR:  res_next = acc_reg | operand;
            OP_XOR: res_next = acc_reg ^ operand;
            OP_SHL: begin res_next = {acc_reg[WIDTH-2:0], 1'b0}; cf_next = acc_reg[WIDTH-1]; end
            OP_MUL: begin res_next = acc_reg; cf_next = cf_reg; end
            default: begin res_next = acc_reg; cf_next = cf_reg; end
        endcase
        // MUL as a single-cycle op (multiplier absent) leaves the flags alone.
        zf_next = (op == OP_MUL) ? zf_reg : (res_next == '0);
    end

`ifdef ALU_ACC_MUL_EN
    logic               mul_start;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_valid;

    assign mul_start = start && (state_reg == ST_IDLE) && (op == OP_MUL);

    mul_seq #(.WIDTH(WIDTH)) u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (acc_reg),
        .b       (operand),
        .product (mul_product),
        .valid   (mul_valid)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            done_reg  <= 1'b0;
            zf_reg    <= 1'b1;
            cf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
`ifdef ALU_ACC_MUL_EN
                        if (op == OP_MUL) begin
                            state_reg <= ST_MUL;
                        end else
`endif
                        begin
                            acc_reg  <= res_next;
                            cf_reg   <= cf_next;
                            zf_reg   <= zf_next;
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
`ifdef ALU_ACC_MUL_EN
                    // acc stays untouched until the final iteration lands.
                    if (mul_valid) begin
                        acc_reg   <= mul_product[WIDTH-1:0];
                        cf_reg    <= |mul_product[2*WIDTH-1:WIDTH];
                        zf_reg    <= (mul_product[WIDTH-1:0] == '0);
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
`else
                    state_reg <= ST_IDLE;
`endif
                end
            endcase
        end
    end

    assign acc  = acc_reg;
    assign busy = (state_reg == ST_MUL);
    assign done = done_reg;
    assign zf   = zf_reg;
    assign cf   = cf_reg;

endmodule

// File: tb/tb_alu_acc.sv
// ---------------------------------------------------------------------------
// tb_alu_acc -- directed bench for alu_acc (WIDTH = 8). An arithmetic
// reference model tracks acc/flags/done/busy every cycle; directed steps add
// hand-computed literal expectations. Multiply checks are compiled when
// ALU_ACC_MUL_EN is defined, the op-111 NOP checks otherwise.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_acc;
    import alu_pkg::*;

    localparam int W = 8;
`ifdef ALU_ACC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    op_e          op = OP_LD;
    logic [W-1:0] operand = '0;
    logic [W-1:0] acc;
    logic         busy, done, zf, cf;

    int npass = 0;
    int ntotal = 0;

    alu_acc #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .acc     (acc),
        .busy    (busy),
        .done    (done),
        .zf      (zf),
        .cf      (cf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    int m_acc, m_a, m_b, m_left;
    bit m_zf, m_cf, m_done, m_ready = 1'b0;

    always @(posedge clk) begin
        int a, b, r, p;
        if (!rst) begin
            m_acc = 0; m_zf = 1; m_cf = 0; m_done = 0; m_left = 0; m_ready = 1;
        end else if (m_left > 0) begin
            m_done = 0;
            m_left--;
            if (m_left == 0) begin
                p = m_a * m_b;
                m_acc = p % 256;
                m_cf = (p / 256) != 0;
                m_zf = (m_acc == 0);
                m_done = 1;
            end
        end else begin
            m_done = 0;
            if (start) begin
                a = m_acc;
                b = int'(operand);
                r = a;
                case (op)
                    OP_LD:  begin r = b;                 m_cf = 0; end
                    OP_ADD: begin r = a + b; m_cf = (r > 255); r = r % 256; end
                    OP_SUB: begin m_cf = (b > a); r = (a - b + 256) % 256; end
                    OP_AND: begin r = a & b;             m_cf = 0; end
                    OP_OR:  begin r = a | b;             m_cf = 0; end
                    OP_XOR: begin r = a ^ b;             m_cf = 0; end
                    OP_SHL: begin m_cf = (a >= 128); r = (a * 2) % 256; end
                    default: r = a;
                endcase
                if (op == OP_MUL && MUL_EN) begin
                    m_a = a; m_b = b; m_left = W;
                end else begin
                    m_done = 1;
                    if (op != OP_MUL) begin
                        m_acc = r;
                        m_zf = (r == 0);
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_ready) begin
            chk("model_acc",  32'(acc),  32'(m_acc));
            chk("model_zf",   32'(zf),   32'(m_zf));
            chk("model_cf",   32'(cf),   32'(m_cf));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_busy", 32'(busy), 32'(m_left > 0));
        end
    end

    // Pulse start for one cycle; returns 2ns into the cycle after acceptance.
    task automatic issue(input op_e o, input logic [W-1:0] d);
        start = 1'b1; op = o; operand = d;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acc", 32'(acc), 32'h00);
        chk("rst_zf", 32'(zf), 32'd1);
        chk("rst_cf", 32'(cf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;

        // LD 0x05
        issue(OP_LD, 8'h05);
        @(negedge clk);
        chk("ld_acc", 32'(acc), 32'h05);
        chk("ld_flags", 32'({zf, cf}), 32'b00);
        chk("ld_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("ld_done_once", 32'(done), 32'd0);

        // ADD with carry, SUB to zero
        @(posedge clk); #2;
        issue(OP_LD, 8'hF0);
        issue(OP_ADD, 8'h20);
        @(negedge clk);
        chk("add_acc", 32'(acc), 32'h10);
        chk("add_flags", 32'({zf, cf}), 32'b01);
        @(posedge clk); #2;
        issue(OP_SUB, 8'h10);
        @(negedge clk);
        chk("sub_acc", 32'(acc), 32'h00);
        chk("sub_flags", 32'({zf, cf}), 32'b10);

        // SUB with borrow, SHL carrying MSB out
        @(posedge clk); #2;
        issue(OP_LD, 8'h03);
        issue(OP_SUB, 8'h05);
        @(negedge clk);
        chk("borrow_acc", 32'(acc), 32'hFE);
        chk("borrow_cf", 32'(cf), 32'd1);
        @(posedge clk); #2;
        issue(OP_SHL, 8'h00);
        @(negedge clk);
        chk("shl_acc", 32'(acc), 32'hFC);
        chk("shl_cf", 32'(cf), 32'd1);

        // Back-to-back logic ops, one start per consecutive cycle
        @(posedge clk); #2;
        issue(OP_LD, 8'h3C);
        issue(OP_XOR, 8'hFF);
        issue(OP_AND, 8'h0F);
        issue(OP_OR, 8'h30);
        @(negedge clk);
        chk("b2b_acc", 32'(acc), 32'h33);
        chk("b2b_done", 32'(done), 32'd1);

`ifdef ALU_ACC_MUL_EN
        // 0x12 * 0x10 = 0x120: busy 8 cycles, stray start mid-way ignored
        @(posedge clk); #2;
        issue(OP_LD, 8'h12);
        issue(OP_MUL, 8'h10);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy", 32'(busy), 32'd1);
            chk("mul_acc_hold", 32'(acc), 32'h12);
            if (i == 3) begin start = 1'b1; op = OP_LD; operand = 8'hAA; end
            else start = 1'b0;
        end
        @(negedge clk);
        chk("mul_busy_end", 32'(busy), 32'd0);
        chk("mul_done", 32'(done), 32'd1);
        chk("mul_acc", 32'(acc), 32'h20);
        chk("mul_flags", 32'({zf, cf}), 32'b01);
        // start in the cycle busy falls
        start = 1'b1; op = OP_ADD; operand = 8'h01;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("post_mul_acc", 32'(acc), 32'h21);
        chk("post_mul_done", 32'(done), 32'd1);

        // Reset during the 4th multiply cycle aborts with no done
        @(posedge clk); #2;
        issue(OP_LD, 8'h12);
        issue(OP_MUL, 8'h10);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_acc", 32'(acc), 32'h00);
        chk("abort_zf", 32'(zf), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
`else
        // op 111 is a one-cycle NOP: acc and flags held, busy never set
        @(posedge clk); #2;
        issue(OP_LD, 8'hFF);
        issue(OP_ADD, 8'h08);
        @(negedge clk);
        chk("pre_nop_acc", 32'(acc), 32'h07);
        chk("pre_nop_flags", 32'({zf, cf}), 32'b01);
        @(posedge clk); #2;
        issue(OP_MUL, 8'h33);
        @(negedge clk);
        chk("nop_acc", 32'(acc), 32'h07);
        chk("nop_flags", 32'({zf, cf}), 32'b01);
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nop_busy_low", 32'(busy), 32'd0);
            chk("nop_done_once", 32'(done), 32'd0);
        end
`endif

        @(posedge clk); #2;
        issue(OP_LD, 8'h42);
        @(negedge clk);
        chk("final_ld_acc", 32'(acc), 32'h42);
        @(posedge clk); #2;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
